// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared constants, types and grant helper for the two-requester round-robin arbiter.
package mux2_rr_arbiter_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY
    } arb_state_e;

    // Winner when idle: a lone requester wins outright, a tie goes to prio.
    function automatic logic pick_grant(input logic v0, input logic v1, input logic prio);
        logic g;
        g = REQ0;
        if (v0 && v1) begin
            g = prio;
        end else if (v1) begin
            g = REQ1;
        end
        return g;
    endfunction

endpackage

// File: rtl/two_to_one_mux.sv
// Gate-level single-bit 2:1 mux.
// Ports: i_a (selected when i_sel=0), i_b (selected when i_sel=1), i_sel, o_y.
module two_to_one_mux (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    logic w_sel_n;
    logic w_a_term;
    logic w_b_term;

    not u_not_sel (w_sel_n, i_sel);
    and u_and_a   (w_a_term, i_a, w_sel_n);
    and u_and_b   (w_b_term, i_b, i_sel);
    or  u_or_y    (o_y, w_a_term, w_b_term);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel between two requesters.
// A grant is held until a last-flagged beat or MAX_BURST accepted beats.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   reqN_valid/data/last, reqN_ready   requester N stream (N = 0, 1)
//   out_valid/data/last, out_ready     shared downstream stream
//   sel                                registered mux select (0 = req0, 1 = req1)
//   busy                               registered, high while a grant is held
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             r_sel;
    logic             w_sel_nxt;
    logic             r_prio;
    logic             w_prio_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_active;
    logic             w_valid_mux;
    logic             w_last_mux;
    logic             w_cnt_max;
    logic             w_accept;
    logic [WIDTH-1:0] w_data_mux;

    assign sel  = r_sel;
    assign busy = (r_state == S_BUSY);

    // Channel is open only while a grant is held and reset is not asserted.
    assign w_active = busy & rst_n;

    // Data path: one mux per bit, all steered by the registered select.
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_data_mux
        two_to_one_mux u_mux_data (
            .i_a   (req0_data[gi]),
            .i_b   (req1_data[gi]),
            .i_sel (r_sel),
            .o_y   (w_data_mux[gi])
        );
    end

    two_to_one_mux u_mux_last (
        .i_a   (req0_last),
        .i_b   (req1_last),
        .i_sel (r_sel),
        .o_y   (w_last_mux)
    );

    two_to_one_mux u_mux_valid (
        .i_a   (req0_valid),
        .i_b   (req1_valid),
        .i_sel (r_sel),
        .o_y   (w_valid_mux)
    );

    assign w_cnt_max  = (r_cnt == CNT_W'(MAX_BURST - 1));
    assign out_data   = w_data_mux;
    assign out_valid  = w_valid_mux & w_active;
    assign out_last   = w_last_mux | (w_active & w_cnt_max);
    assign req0_ready = w_active & (r_sel == REQ0) & out_ready;
    assign req1_ready = w_active & (r_sel == REQ1) & out_ready;
    assign w_accept   = out_valid & out_ready;

    // State, select, priority and beat counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= REQ0;
            r_prio  <= REQ0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_prio  <= w_prio_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Grant, burst counting and release.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    w_state_nxt = S_BUSY;
                    w_sel_nxt   = pick_grant(req0_valid, req1_valid, r_prio);
                    w_cnt_nxt   = '0;
                end
            end
            S_BUSY: begin
                if (w_accept) begin
                    if (out_last) begin
                        w_state_nxt = S_IDLE;
                        w_prio_nxt  = ~r_sel;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       sel;
    logic       busy;

    int total;
    int bad;

    mux2_rr_arbiter #(
        .WIDTH     (8),
        .MAX_BURST (4),
        .CNT_W     (3)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .sel        (sel),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic       ol;
        logic       r0;
        logic       r1;
        logic       sel;
        logic       busy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic rs, input logic v0, input logic [7:0] d0, input logic l0,
        input logic v1, input logic [7:0] d1, input logic l1, input logic ordy,
        input logic ov, input logic [7:0] od, input logic ol,
        input logic r0, input logic r1, input logic sl, input logic bz);
        vec_t v;
        v.rst_n = rs; v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.l1 = l1; v.ordy = ordy;
        v.ov = ov; v.od = od; v.ol = ol; v.r0 = r0; v.r1 = r1;
        v.sel = sl; v.busy = bz;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n      = v.rst_n;
        req0_valid = v.v0;
        req0_data  = v.d0;
        req0_last  = v.l0;
        req1_valid = v.v1;
        req1_data  = v.d1;
        req1_last  = v.l1;
        out_ready  = v.ordy;
    endtask

    initial begin
        int  n;
        bit  got;
        total = 0;
        bad   = 0;

        // rst, v0,d0,l0, v1,d1,l1, ordy | ov,od,ol, r0,r1, sel,busy
        // reset hold with both requesters valid
        vq.push_back(mk(0, 1,8'hA0,0, 1,8'hB0,0, 1,  0,8'h00,0, 0,0, 0,0));
        vq.push_back(mk(0, 1,8'hA0,0, 1,8'hB0,0, 1,  0,8'h00,0, 0,0, 0,0));
        // contention round robin, 2-beat bursts
        vq.push_back(mk(1, 1,8'hA0,0, 1,8'hB0,0, 1,  0,8'h00,0, 0,0, 0,0));
        vq.push_back(mk(1, 1,8'hA0,0, 1,8'hB0,0, 1,  1,8'hA0,0, 1,0, 0,1));
        vq.push_back(mk(1, 1,8'hA1,1, 1,8'hB0,0, 1,  1,8'hA1,1, 1,0, 0,1));
        vq.push_back(mk(1, 1,8'hA0,0, 1,8'hB0,0, 1,  0,8'h00,0, 0,0, 0,0));
        vq.push_back(mk(1, 1,8'hA0,0, 1,8'hB0,0, 1,  1,8'hB0,0, 0,1, 1,1));
        vq.push_back(mk(1, 1,8'hA0,0, 1,8'hB1,1, 1,  1,8'hB1,1, 0,1, 1,1));
        vq.push_back(mk(1, 1,8'hA0,0, 1,8'hB0,0, 1,  0,8'h00,0, 0,0, 1,0));
        vq.push_back(mk(1, 1,8'hA0,0, 1,8'hB0,0, 1,  1,8'hA0,0, 1,0, 0,1));
        vq.push_back(mk(1, 1,8'hA1,1, 1,8'hB0,0, 1,  1,8'hA1,1, 1,0, 0,1));
        // single requester 1
        vq.push_back(mk(1, 0,8'h00,0, 1,8'h11,0, 1,  0,8'h00,0, 0,0, 0,0));
        vq.push_back(mk(1, 0,8'h00,0, 1,8'h11,0, 1,  1,8'h11,0, 0,1, 1,1));
        vq.push_back(mk(1, 0,8'h00,0, 1,8'h22,1, 1,  1,8'h22,1, 0,1, 1,1));
        // lone requester 1 wins even though prio favours 0
        vq.push_back(mk(1, 0,8'h00,0, 1,8'h33,1, 1,  0,8'h00,0, 0,0, 1,0));
        vq.push_back(mk(1, 0,8'h00,0, 1,8'h33,1, 1,  1,8'h33,1, 0,1, 1,1));
        vq.push_back(mk(1, 0,8'h00,0, 0,8'h00,0, 1,  0,8'h00,0, 0,0, 1,0));
        // long burst: backpressure, valid drop, forced release
        vq.push_back(mk(1, 1,8'hC0,0, 0,8'h00,0, 1,  0,8'h00,0, 0,0, 1,0));
        vq.push_back(mk(1, 1,8'hC0,0, 0,8'h00,0, 1,  1,8'hC0,0, 1,0, 0,1));
        vq.push_back(mk(1, 1,8'hC1,0, 1,8'hD0,1, 0,  1,8'hC1,0, 0,0, 0,1));
        vq.push_back(mk(1, 1,8'hC1,0, 1,8'hD0,1, 0,  1,8'hC1,0, 0,0, 0,1));
        vq.push_back(mk(1, 1,8'hC1,0, 1,8'hD0,1, 0,  1,8'hC1,0, 0,0, 0,1));
        vq.push_back(mk(1, 1,8'hC1,0, 1,8'hD0,1, 1,  1,8'hC1,0, 1,0, 0,1));
        vq.push_back(mk(1, 0,8'h00,0, 1,8'hD0,1, 1,  0,8'h00,0, 1,0, 0,1));
        vq.push_back(mk(1, 1,8'hC2,0, 1,8'hD0,1, 1,  1,8'hC2,0, 1,0, 0,1));
        vq.push_back(mk(1, 1,8'hC3,0, 1,8'hD0,1, 1,  1,8'hC3,1, 1,0, 0,1));
        vq.push_back(mk(1, 1,8'hC4,0, 1,8'hD0,1, 1,  0,8'h00,0, 0,0, 0,0));
        vq.push_back(mk(1, 1,8'hC4,0, 1,8'hD0,1, 1,  1,8'hD0,1, 0,1, 1,1));
        vq.push_back(mk(1, 1,8'hC4,0, 0,8'h00,0, 1,  0,8'h00,0, 0,0, 1,0));
        vq.push_back(mk(1, 1,8'hC4,0, 0,8'h00,0, 1,  1,8'hC4,0, 1,0, 0,1));
        vq.push_back(mk(1, 1,8'hC5,1, 0,8'h00,0, 1,  1,8'hC5,1, 1,0, 0,1));
        vq.push_back(mk(1, 0,8'h00,0, 0,8'h00,0, 1,  0,8'h00,0, 0,0, 0,0));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(negedge clk);
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vq[i].ov));
            chk($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(vq[i].r0));
            chk($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(vq[i].r1));
            chk($sformatf("v%0d sel", i), 32'(sel), 32'(vq[i].sel));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vq[i].busy));
            if (vq[i].ov) begin
                chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vq[i].od));
                chk($sformatf("v%0d out_last", i), 32'(out_last), 32'(vq[i].ol));
            end
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a requester-1 burst.
        rst_n = 1'b1; out_ready = 1'b1;
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b1; req1_data = 8'hE0; req1_last = 1'b0;
        n = 0; got = 1'b0;
        while (n < 4 && !got) begin
            @(negedge clk);
            if (busy === 1'b1 && sel === 1'b1) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("rst_mid grant_wait", 32'(got), 32'd1);
        chk("rst_mid beat0 data", 32'(out_data), 32'hE0);
        chk("rst_mid beat0 ready", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_data = 8'hE1;
        @(negedge clk);
        chk("rst_mid beat1 data", 32'(out_data), 32'hE1);
        chk("rst_mid beat1 last", 32'(out_last), 32'd0);
        @(posedge clk); #1;
        req1_data = 8'hE2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid beat2 ready", 32'(req1_ready), 32'd0);
        chk("rst_mid beat2 valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_data = 8'hF0; req0_last = 1'b0;
        @(negedge clk);
        chk("rst_mid idle busy", 32'(busy), 32'd0);
        chk("rst_mid idle sel", 32'(sel), 32'd0);
        @(posedge clk); #1;
        // prio back to 0 and counter cleared: req0 wins, forced last on 4th beat
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                @(posedge clk); #1;
                req0_data = 8'(8'hF0 + b);
            end
            @(negedge clk);
            chk($sformatf("post_rst b%0d sel", b), 32'(sel), 32'd0);
            chk($sformatf("post_rst b%0d busy", b), 32'(busy), 32'd1);
            chk($sformatf("post_rst b%0d data", b), 32'(out_data), 32'(8'hF0 + b));
            chk($sformatf("post_rst b%0d last", b), 32'(out_last), (b == 3) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("post_rst release busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
